mem_wb_stage: RTL and testbench
===============================

// Module: mem_wb_stage
// PURPOSE
//  Memory/writeback stage fed by the ex->mem/wb pipeline register.
//  - Issues stores to the data-memory bus with a req/gnt handshake.
//  - Aligns and extends BRAM load data (read request was issued in EX).
//  - Registers the final GPR and CSR writeback.
//  - Raises hold_req_o to the pipeline controller while a store cannot be accepted.
// PARAMETERS
//  XLEN      32  register, memory-data and address width
//  REG_AW    5   GPR address width
//  CSR_AW    12  CSR address width
// PORTS
//  clk                 in   1       clock; all state updates on rising edge
//  rst                 in   1       synchronous reset, active-high
//  ex_w_reg_enable_i   in   1       write ex_w_reg_data_i to GPR
//  mem_w_reg_enable_i  in   1       load: write aligned r_mem_data_i to GPR
//  w_reg_addr_i        in   REG_AW  GPR destination
//  ex_w_reg_data_i     in   XLEN    ALU result
//  w_mem_addr_i        in   XLEN    effective address (stores and loads)
//  w_mem_enable_i      in   1       store request
//  w_mem_data_i        in   XLEN    store data, LSB-aligned
//  data_type_i         in   3       0 none, 1 B, 2 BU, 3 H, 4 HU, 5 W
//  r_mem_data_i        in   XLEN    BRAM read word for the load in this stage
//  ex_w_csr_enable_i   in   1       CSR write enable
//  ex_w_csr_addr_i     in   CSR_AW  CSR address
//  ex_w_csr_data_i     in   XLEN    CSR data
//  dmem_req_o          out  1       store request valid
//  dmem_addr_o         out  XLEN    word-aligned store address ({addr[31:2],2'b00})
//  dmem_wdata_o        out  XLEN    lane-replicated store data
//  dmem_be_o           out  4       byte enables
//  dmem_gnt_i          in   1       store accepted this cycle
//  hold_req_o          out  1       combinational stall request to pipeline control
//  misalign_o          out  1       one-cycle pulse: misaligned access dropped
//  wb_reg_enable_o     out  1       GPR write enable (registered)
//  wb_reg_addr_o       out  REG_AW  GPR write address
//  wb_reg_data_o       out  XLEN    GPR write data
//  wb_csr_enable_o     out  1       CSR write enable (registered)
//  wb_csr_addr_o       out  CSR_AW  CSR address
//  wb_csr_data_o       out  XLEN    CSR data
// BEHAVIOUR
//  Reset
//  - rst=1 -> state IDLE.
//  - All wb_*, dmem_*, misalign_o -> 0.
//  - An in-flight store is dropped; no gnt is awaited.
//  Writeback (latency 1, suppressed while hold_req_o=1)
//  - Source select: ex_w_reg_enable_i -> ALU data; mem_w_reg_enable_i -> load data.
//  - w_reg_addr_i==0 forces wb_reg_enable_o=0.
//  - Load extraction: lane = addr[1:0]; B/H sign-extend, BU/HU zero-extend, W unchanged.
//  - CSR fields pass through registered, same latency as GPR writeback.
//  Store encoding
//  - B: be=4'b0001<<addr[1:0]; wdata = byte replicated x4.
//  - H: be=4'b0011<<addr[1:0]; wdata = half replicated x2.
//  - W: be=4'b1111.
//  Misalignment
//  - Covers H with addr[0]=1 and W with addr[1:0]!=0.
//  - No dmem_req; misalign_o=1 for 1 cycle.
//  - For a misaligned load, GPR write is suppressed.
//  FSM
//  - IDLE:
//    - Aligned store captures addr/wdata/be into store registers -> REQ.
//    - In the next cycle dmem_req_o=1.
//  - REQ:
//    - dmem_req_o and payload held stable until dmem_gnt_i=1.
//    - gnt=1 -> IDLE, or directly to REQ with a newly accepted store (see CONFIGURATION).
//  - dmem_gnt_i in IDLE is ignored.
//  hold_req_o
//  - While hold_req_o=1, upstream holds its inputs.
//  - This stage neither re-captures the held store nor re-writes back held data.
// CONFIGURATION
//  STORE_BUF_EN undefined (blocking)
//  - hold_req_o=1 in every REQ cycle, including the gnt cycle.
//  - Store-to-store issue spacing is >= 2 cycles.
//  STORE_BUF_EN defined (one-entry store buffer)
//  - In REQ, hold_req_o=1 only when the incoming op is a memory op (store, or load
//    with mem_w_reg_enable_i=1) and dmem_gnt_i=0.
//  - ALU/CSR instructions retire under an outstanding store.
//  - Store with gnt=1 in the same cycle -> captured and REQ kept (back-to-back, no stall).
// TESTING
//  1 LB at addr 0x...3, r_mem_data_i=0x80FF_1234 -> next cycle wb_reg_data_o=0xFFFF_FF80, enable=1.
//  2 SH addr 0x...2, data 0x0000_ABCD -> dmem_be_o=4'b1100, wdata=0xABCD_ABCD,
//    req held 3 cycles until gnt, then IDLE.
//  3 SW addr 0x...1 -> no dmem_req_o, misalign_o pulses 1 cycle.
//    LW addr 0x...2 -> misalign_o pulses, wb_reg_enable_o=0.
//  4 ALU write to x0 -> wb_reg_enable_o=0; CSR write 0x300/0x8 appears 1 cycle later.
//  5 Two back-to-back SW, gnt on 2nd REQ cycle:
//    - without STORE_BUF_EN: hold_req_o high all REQ cycles.
//    - with STORE_BUF_EN: hold only for the first; ALU op retires under the outstanding store.
//  6 rst asserted in REQ with gnt=0 -> next cycle dmem_req_o=0, state IDLE, all wb_* = 0.

Source files
------------

// File: rtl/mem_wb_stage.sv
// Memory/writeback stage: store issue over a req/gnt bus, load alignment, GPR/CSR writeback.
// Build option STORE_BUF_EN: one-entry store buffer so non-memory ops retire under an outstanding store.
module mem_wb_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CSR_AW = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_w_reg_enable_i,
    input  logic              mem_w_reg_enable_i,
    input  logic [REG_AW-1:0] w_reg_addr_i,
    input  logic [XLEN-1:0]   ex_w_reg_data_i,
    input  logic [XLEN-1:0]   w_mem_addr_i,
    input  logic              w_mem_enable_i,
    input  logic [XLEN-1:0]   w_mem_data_i,
    input  logic [2:0]        data_type_i,
    input  logic [XLEN-1:0]   r_mem_data_i,
    input  logic              ex_w_csr_enable_i,
    input  logic [CSR_AW-1:0] ex_w_csr_addr_i,
    input  logic [XLEN-1:0]   ex_w_csr_data_i,
    output logic              dmem_req_o,
    output logic [XLEN-1:0]   dmem_addr_o,
    output logic [XLEN-1:0]   dmem_wdata_o,
    output logic [3:0]        dmem_be_o,
    input  logic              dmem_gnt_i,
    output logic              hold_req_o,
    output logic              misalign_o,
    output logic              wb_reg_enable_o,
    output logic [REG_AW-1:0] wb_reg_addr_o,
    output logic [XLEN-1:0]   wb_reg_data_o,
    output logic              wb_csr_enable_o,
    output logic [CSR_AW-1:0] wb_csr_addr_o,
    output logic [XLEN-1:0]   wb_csr_data_o
);

    localparam logic [2:0] DT_B  = 3'd1;
    localparam logic [2:0] DT_BU = 3'd2;
    localparam logic [2:0] DT_H  = 3'd3;
    localparam logic [2:0] DT_HU = 3'd4;
    localparam logic [2:0] DT_W  = 3'd5;

    typedef enum logic {IDLE, REQ} state_t;

    state_t          state;
    state_t          state_next;

    logic [1:0]      lane;
    logic            is_byte;
    logic            is_half;
    logic            is_word;
    logic            misaligned;
    logic            mem_op;
    logic            accept;
    logic            store_valid;
    logic            capture;
    logic            mis_event;
    logic            reg_write;
    logic [7:0]      load_byte;
    logic [15:0]     load_half;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] st_wdata;
    logic [3:0]      st_be;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        lane       = w_mem_addr_i[1:0];
        is_byte    = (data_type_i == DT_B) || (data_type_i == DT_BU);
        is_half    = (data_type_i == DT_H) || (data_type_i == DT_HU);
        is_word    = (data_type_i == DT_W);
        misaligned = (is_half && lane[0]) || (is_word && (lane != 2'b00));
        mem_op     = w_mem_enable_i || mem_w_reg_enable_i;
    end

    // Everything below acts only on an op that is not being held upstream.
    always_comb begin
        accept      = !hold_req_o;
        store_valid = w_mem_enable_i && (is_byte || is_half || is_word);
        capture     = accept && store_valid && !misaligned;
        mis_event   = accept && (store_valid || mem_w_reg_enable_i) && misaligned;
        reg_write   = accept && (w_reg_addr_i != '0)
                      && (ex_w_reg_enable_i || (mem_w_reg_enable_i && !misaligned));
    end

    always_comb begin
        load_byte = r_mem_data_i[{lane, 3'b000} +: 8];
        load_half = r_mem_data_i[{lane[1], 4'b0000} +: 16];
        load_data = r_mem_data_i;
        case (data_type_i)
            DT_B:    load_data = {{(XLEN-8){load_byte[7]}}, load_byte};
            DT_BU:   load_data = {{(XLEN-8){1'b0}}, load_byte};
            DT_H:    load_data = {{(XLEN-16){load_half[15]}}, load_half};
            DT_HU:   load_data = {{(XLEN-16){1'b0}}, load_half};
            default: load_data = r_mem_data_i;
        endcase
    end

    // Sub-word stores replicate the payload into every lane; byte enables pick the live one.
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = w_mem_data_i;
        if (is_byte) begin
            st_be    = 4'b0001 << lane;
            st_wdata = {4{w_mem_data_i[7:0]}};
        end else if (is_half) begin
            st_be    = 4'b0011 << lane;
            st_wdata = {2{w_mem_data_i[15:0]}};
        end
    end

    // NOTE: synchronous reset, sampled on the clock edge like any other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (capture) state_next = REQ;
            REQ:     if (dmem_gnt_i) state_next = capture ? REQ : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        dmem_req_o = (state == REQ);
`ifdef STORE_BUF_EN
        hold_req_o = (state == REQ) && mem_op && !dmem_gnt_i;
`else
        hold_req_o = (state == REQ);
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_o      <= 1'b0;
            wb_reg_enable_o <= 1'b0;
            wb_reg_addr_o   <= '0;
            wb_reg_data_o   <= '0;
            wb_csr_enable_o <= 1'b0;
            wb_csr_addr_o   <= '0;
            wb_csr_data_o   <= '0;
            dmem_addr_o     <= '0;
            dmem_wdata_o    <= '0;
            dmem_be_o       <= '0;
        end else begin
            misalign_o      <= mis_event;
            wb_reg_enable_o <= reg_write;
            wb_csr_enable_o <= accept && ex_w_csr_enable_i;
            if (accept) begin
                wb_reg_addr_o <= w_reg_addr_i;
                wb_reg_data_o <= ex_w_reg_enable_i ? ex_w_reg_data_i : load_data;
                wb_csr_addr_o <= ex_w_csr_addr_i;
                wb_csr_data_o <= ex_w_csr_data_i;
            end
            // Payload only changes on capture, so it stays stable for the whole request.
            if (capture) begin
                dmem_addr_o  <= {w_mem_addr_i[XLEN-1:2], 2'b00};
                dmem_wdata_o <= st_wdata;
                dmem_be_o    <= st_be;
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed vector table, multi-cycle store sequences,
// and random traffic compared against a size/offset-based reference model.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_w_reg_enable_i;
    logic        mem_w_reg_enable_i;
    logic [4:0]  w_reg_addr_i;
    logic [31:0] ex_w_reg_data_i;
    logic [31:0] w_mem_addr_i;
    logic        w_mem_enable_i;
    logic [31:0] w_mem_data_i;
    logic [2:0]  data_type_i;
    logic [31:0] r_mem_data_i;
    logic        ex_w_csr_enable_i;
    logic [11:0] ex_w_csr_addr_i;
    logic [31:0] ex_w_csr_data_i;
    logic        dmem_req_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        dmem_gnt_i;
    logic        hold_req_o;
    logic        misalign_o;
    logic        wb_reg_enable_o;
    logic [4:0]  wb_reg_addr_o;
    logic [31:0] wb_reg_data_o;
    logic        wb_csr_enable_o;
    logic [11:0] wb_csr_addr_o;
    logic [31:0] wb_csr_data_o;

    mem_wb_stage dut (
        .clk                (clk),
        .rst                (rst),
        .ex_w_reg_enable_i  (ex_w_reg_enable_i),
        .mem_w_reg_enable_i (mem_w_reg_enable_i),
        .w_reg_addr_i       (w_reg_addr_i),
        .ex_w_reg_data_i    (ex_w_reg_data_i),
        .w_mem_addr_i       (w_mem_addr_i),
        .w_mem_enable_i     (w_mem_enable_i),
        .w_mem_data_i       (w_mem_data_i),
        .data_type_i        (data_type_i),
        .r_mem_data_i       (r_mem_data_i),
        .ex_w_csr_enable_i  (ex_w_csr_enable_i),
        .ex_w_csr_addr_i    (ex_w_csr_addr_i),
        .ex_w_csr_data_i    (ex_w_csr_data_i),
        .dmem_req_o         (dmem_req_o),
        .dmem_addr_o        (dmem_addr_o),
        .dmem_wdata_o       (dmem_wdata_o),
        .dmem_be_o          (dmem_be_o),
        .dmem_gnt_i         (dmem_gnt_i),
        .hold_req_o         (hold_req_o),
        .misalign_o         (misalign_o),
        .wb_reg_enable_o    (wb_reg_enable_o),
        .wb_reg_addr_o      (wb_reg_addr_o),
        .wb_reg_data_o      (wb_reg_data_o),
        .wb_csr_enable_o    (wb_csr_enable_o),
        .wb_csr_addr_o      (wb_csr_addr_o),
        .wb_csr_data_o      (wb_csr_data_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          ex_en;
        bit          mem_en;
        bit          st_en;
        logic [2:0]  dt;
        logic [4:0]  ra;
        logic [31:0] alu;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        bit          csr_en;
        logic [11:0] csr_a;
        logic [31:0] csr_d;
    } instr_t;

    typedef struct {
        instr_t      in;
        bit          en;
        logic [31:0] data;
        bit          mis;
        bit          csr_en;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // Reference model state: at most one outstanding store plus the expected registered outputs.
    bit          m_pending = 1'b0;
    logic [31:0] m_addr, m_wd;
    logic [3:0]  m_be;
    bit          e_wb_en, e_csr_en, e_mis;
    logic [4:0]  e_wb_addr;
    logic [31:0] e_wb_data, e_csr_d;
    logic [11:0] e_csr_a;

    instr_t prog[$];
    vec_t   tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic instr_t nop_i();
        instr_t i;
        i = '{default: '0};
        return i;
    endfunction

    function automatic instr_t ld_i(input logic [2:0] dt, input logic [31:0] addr,
                                    input logic [31:0] rd, input logic [4:0] ra);
        instr_t i = nop_i();
        i.mem_en = 1'b1; i.dt = dt; i.addr = addr; i.rd = rd; i.ra = ra;
        return i;
    endfunction

    function automatic instr_t st_i(input logic [2:0] dt, input logic [31:0] addr, input logic [31:0] wd);
        instr_t i = nop_i();
        i.st_en = 1'b1; i.dt = dt; i.addr = addr; i.wd = wd;
        return i;
    endfunction

    function automatic instr_t alu_i(input logic [4:0] ra, input logic [31:0] v);
        instr_t i = nop_i();
        i.ex_en = 1'b1; i.ra = ra; i.alu = v;
        return i;
    endfunction

    function automatic instr_t with_csr(input instr_t i, input logic [11:0] a, input logic [31:0] d);
        instr_t r = i;
        r.csr_en = 1'b1; r.csr_a = a; r.csr_d = d;
        return r;
    endfunction

    function automatic vec_t mkv(input instr_t in, input bit en, input logic [31:0] data,
                                 input bit mis, input bit csr_en);
        vec_t v;
        v.in = in; v.en = en; v.data = data; v.mis = mis; v.csr_en = csr_en;
        return v;
    endfunction

    function automatic instr_t rand_i();
        instr_t i = nop_i();
        int kind = $urandom_range(0, 4);
        i.dt     = 3'($urandom_range(0, 7));
        i.ra     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        i.alu    = $urandom;
        i.addr   = $urandom;
        i.wd     = $urandom;
        i.rd     = $urandom;
        i.csr_en = ($urandom_range(0, 3) == 0);
        i.csr_a  = 12'($urandom);
        i.csr_d  = $urandom;
        case (kind)
            0: i.ex_en = 1'b1;
            1: i.mem_en = 1'b1;
            2: i.st_en = 1'b1;
            3: begin i.st_en = 1'b1; i.addr[1:0] = 2'b00; end
            default: ;
        endcase
        return i;
    endfunction

    // Access size in bytes for a data type; 0 means no memory access.
    function automatic int size_of(input logic [2:0] dt);
        case (dt)
            3'd1, 3'd2: return 1;
            3'd3, 3'd4: return 2;
            3'd5:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic logic [31:0] load_value(input instr_t in);
        int     sz = size_of(in.dt);
        longint v, full;
        if (sz == 0 || sz == 4) return in.rd;
        v    = longint'(in.rd >> (8 * int'(in.addr[1:0])));
        full = longint'(1) << (8 * sz);
        v    = v % full;
        if ((in.dt == 3'd1 || in.dt == 3'd3) && v >= full / 2) v = v - full;
        return v[31:0];
    endfunction

    function automatic logic [3:0] store_be(input instr_t in);
        int sz = size_of(in.dt);
        return 4'(((1 << sz) - 1) << int'(in.addr[1:0]));
    endfunction

    function automatic logic [31:0] store_wdata(input instr_t in);
        logic [31:0] w;
        int          sz = size_of(in.dt);
        for (int b = 0; b < 4; b++) w[8*b +: 8] = in.wd[8*(b % sz) +: 8];
        return w;
    endfunction

    task automatic drive(input instr_t i);
        ex_w_reg_enable_i  = i.ex_en;
        mem_w_reg_enable_i = i.mem_en;
        w_reg_addr_i       = i.ra;
        ex_w_reg_data_i    = i.alu;
        w_mem_addr_i       = i.addr;
        w_mem_enable_i     = i.st_en;
        w_mem_data_i       = i.wd;
        data_type_i        = i.dt;
        r_mem_data_i       = i.rd;
        ex_w_csr_enable_i  = i.csr_en;
        ex_w_csr_addr_i    = i.csr_a;
        ex_w_csr_data_i    = i.csr_d;
    endtask

    // One clock of stimulus checked against the model: hold before the edge, registered outputs after.
    task automatic cycle_model(input instr_t in, input bit g, output bit acc, output bit cap,
                               output bit obs_hold, output bit obs_req);
        bit exp_hold, mis, stv;
        int sz, off;
        drive(in);
        dmem_gnt_i = g;
        #1;
        obs_hold = hold_req_o;
        obs_req  = dmem_req_o;
`ifdef STORE_BUF_EN
        exp_hold = m_pending && (in.st_en || in.mem_en) && !g;
`else
        exp_hold = m_pending;
`endif
        check("hold_req", hold_req_o, exp_hold);
        sz  = size_of(in.dt);
        off = int'(in.addr[1:0]);
        mis = (sz != 0) && ((off % sz) != 0);
        stv = in.st_en && (sz != 0);
        acc = !exp_hold;
        cap = 1'b0;
        if (m_pending && g) m_pending = 1'b0;
        e_wb_en = 1'b0; e_csr_en = 1'b0; e_mis = 1'b0;
        if (acc) begin
            e_mis     = (stv || in.mem_en) && mis;
            e_wb_en   = (in.ra != 0) && (in.ex_en || (in.mem_en && !mis));
            e_wb_addr = in.ra;
            e_wb_data = in.ex_en ? in.alu : load_value(in);
            e_csr_en  = in.csr_en;
            e_csr_a   = in.csr_a;
            e_csr_d   = in.csr_d;
            if (stv && !mis) begin
                cap       = 1'b1;
                m_pending = 1'b1;
                m_addr    = in.addr & 32'hFFFF_FFFC;
                m_be      = store_be(in);
                m_wd      = store_wdata(in);
            end
        end
        @(posedge clk);
        #1;
        check("wb_en", wb_reg_enable_o, e_wb_en);
        if (e_wb_en) begin
            check("wb_addr", wb_reg_addr_o, e_wb_addr);
            check("wb_data", wb_reg_data_o, e_wb_data);
        end
        check("csr_en", wb_csr_enable_o, e_csr_en);
        if (e_csr_en) begin
            check("csr_addr", wb_csr_addr_o, e_csr_a);
            check("csr_data", wb_csr_data_o, e_csr_d);
        end
        check("misalign", misalign_o, e_mis);
        check("dmem_req", dmem_req_o, m_pending);
        if (m_pending) begin
            check("dmem_addr", dmem_addr_o, m_addr);
            check("dmem_be", dmem_be_o, m_be);
            check("dmem_wdata", dmem_wdata_o, m_wd);
        end
    endtask

    // Feeds prog in order, advancing only when the op is accepted. gnt_age>=0 grants on that
    // REQ cycle (0 = first); gnt_age<0 grants randomly.
    task automatic run_prog(input int gnt_age, input int max_cycles, output int holds, output int reqs);
        int idx = 0;
        int age = 0;
        int cyc = 0;
        bit g, acc, cap, oh, orq;
        holds = 0;
        reqs  = 0;
        while (idx < prog.size() && cyc < max_cycles) begin
            if (gnt_age < 0) g = ($urandom_range(0, 2) == 0);
            else             g = m_pending && (age == gnt_age);
            cycle_model(prog[idx], g, acc, cap, oh, orq);
            holds += int'(oh);
            reqs  += int'(orq);
            if (acc) idx++;
            if (cap)            age = 0;
            else if (m_pending) age++;
            else                age = 0;
            cyc++;
        end
        if (idx < prog.size()) begin
            total++;
            bad++;
            $display("FAIL prog_timeout: consumed %0d of %0d ops", idx, prog.size());
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(nop_i());
        dmem_gnt_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b0;
        m_pending = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int holds, reqs;
        bit acc, cap, oh, orq;

        rst = 1'b1;
        drive(nop_i());
        dmem_gnt_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst wb_en", wb_reg_enable_o, 0);
        check("rst wb_addr", wb_reg_addr_o, 0);
        check("rst wb_data", wb_reg_data_o, 0);
        check("rst csr_en", wb_csr_enable_o, 0);
        check("rst csr_addr", wb_csr_addr_o, 0);
        check("rst csr_data", wb_csr_data_o, 0);
        check("rst dmem_req", dmem_req_o, 0);
        check("rst dmem_addr", dmem_addr_o, 0);
        check("rst dmem_wdata", dmem_wdata_o, 0);
        check("rst dmem_be", dmem_be_o, 0);
        check("rst misalign", misalign_o, 0);
        check("rst hold", hold_req_o, 0);
        rst = 1'b0;

        // Single-cycle ops from IDLE with hand-computed expectations.
        tbl.push_back(mkv(ld_i(3'd1, 32'h0000_1003, 32'h80FF_1234, 5'd5), 1, 32'hFFFF_FF80, 0, 0));
        tbl.push_back(mkv(ld_i(3'd2, 32'h0000_1003, 32'h80FF_1234, 5'd5), 1, 32'h0000_0080, 0, 0));
        tbl.push_back(mkv(ld_i(3'd1, 32'h0000_1001, 32'h80FF_1234, 5'd6), 1, 32'h0000_0012, 0, 0));
        tbl.push_back(mkv(ld_i(3'd3, 32'h0000_1002, 32'h80FF_1234, 5'd7), 1, 32'hFFFF_80FF, 0, 0));
        tbl.push_back(mkv(ld_i(3'd3, 32'h0000_1000, 32'h80FF_9234, 5'd7), 1, 32'hFFFF_9234, 0, 0));
        tbl.push_back(mkv(ld_i(3'd4, 32'h0000_1000, 32'h80FF_9234, 5'd8), 1, 32'h0000_9234, 0, 0));
        tbl.push_back(mkv(ld_i(3'd5, 32'h0000_1004, 32'hDEAD_BEEF, 5'd9), 1, 32'hDEAD_BEEF, 0, 0));
        tbl.push_back(mkv(ld_i(3'd5, 32'h0000_1002, 32'hDEAD_BEEF, 5'd9), 0, 32'h0, 1, 0));
        tbl.push_back(mkv(nop_i(), 0, 32'h0, 0, 0));
        tbl.push_back(mkv(ld_i(3'd4, 32'h0000_1001, 32'hDEAD_BEEF, 5'd3), 0, 32'h0, 1, 0));
        tbl.push_back(mkv(st_i(3'd5, 32'h0000_2001, 32'h1234_5678), 0, 32'h0, 1, 0));
        tbl.push_back(mkv(st_i(3'd3, 32'h0000_2003, 32'h1234_5678), 0, 32'h0, 1, 0));
        tbl.push_back(mkv(with_csr(alu_i(5'd0, 32'h0000_1234), 12'h300, 32'h8), 0, 32'h0, 0, 1));
        tbl.push_back(mkv(alu_i(5'd7, 32'hCAFE_F00D), 1, 32'hCAFE_F00D, 0, 0));
        tbl.push_back(mkv(ld_i(3'd1, 32'h0000_1003, 32'h80FF_1234, 5'd0), 0, 32'h0, 0, 0));
        foreach (tbl[k]) begin
            drive(tbl[k].in);
            dmem_gnt_i = 1'b0;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d wb_en", k), wb_reg_enable_o, tbl[k].en);
            if (tbl[k].en) check($sformatf("vec%0d wb_data", k), wb_reg_data_o, tbl[k].data);
            check($sformatf("vec%0d misalign", k), misalign_o, tbl[k].mis);
            check($sformatf("vec%0d csr_en", k), wb_csr_enable_o, tbl[k].csr_en);
            if (tbl[k].csr_en) begin
                check($sformatf("vec%0d csr_addr", k), wb_csr_addr_o, 32'h300);
                check($sformatf("vec%0d csr_data", k), wb_csr_data_o, 32'h8);
            end
            check($sformatf("vec%0d dmem_req", k), dmem_req_o, 0);
        end

        // SH to lane 2, granted on the third REQ cycle.
        do_reset();
        cycle_model(st_i(3'd3, 32'h0000_1002, 32'h0000_ABCD), 1'b0, acc, cap, oh, orq);
        check("sh dmem_req", dmem_req_o, 1);
        check("sh dmem_be", dmem_be_o, 4'b1100);
        check("sh dmem_wdata", dmem_wdata_o, 32'hABCD_ABCD);
        check("sh dmem_addr", dmem_addr_o, 32'h0000_1000);
        prog.delete();
        repeat (4) prog.push_back(nop_i());
        run_prog(2, 40, holds, reqs);
        check("sh req_cycles", reqs, 3);
        check("sh idle", dmem_req_o, 0);

        // Back-to-back SW then an ALU op, each store granted on its second REQ cycle.
        do_reset();
        prog.delete();
        prog.push_back(st_i(3'd5, 32'h0000_2000, 32'h1111_1111));
        prog.push_back(st_i(3'd5, 32'h0000_2004, 32'h2222_2222));
        prog.push_back(alu_i(5'd9, 32'h0000_5A5A));
        run_prog(1, 40, holds, reqs);
`ifdef STORE_BUF_EN
        check("b2b hold_cycles", holds, 1);
        check("b2b alu_under_store", dmem_req_o, 1);
`else
        check("b2b hold_cycles", holds, 4);
`endif
        check("b2b alu wb_en", wb_reg_enable_o, 1);
        check("b2b alu wb_addr", wb_reg_addr_o, 9);
        check("b2b alu wb_data", wb_reg_data_o, 32'h0000_5A5A);
        prog.delete();
        repeat (3) prog.push_back(nop_i());
        run_prog(1, 40, holds, reqs);
        check("b2b drained", dmem_req_o, 0);

        // Reset while a store waits for gnt; a later gnt in IDLE must not raise a request.
        do_reset();
        cycle_model(st_i(3'd5, 32'h0000_3000, 32'hDEAD_BEEF), 1'b0, acc, cap, oh, orq);
        rst = 1'b1;
        drive(nop_i());
        dmem_gnt_i = 1'b0;
        @(posedge clk);
        #1;
        check("rst_req dmem_req", dmem_req_o, 0);
        check("rst_req dmem_be", dmem_be_o, 0);
        check("rst_req hold", hold_req_o, 0);
        check("rst_req wb_en", wb_reg_enable_o, 0);
        check("rst_req wb_data", wb_reg_data_o, 0);
        check("rst_req csr_en", wb_csr_enable_o, 0);
        check("rst_req misalign", misalign_o, 0);
        rst       = 1'b0;
        m_pending = 1'b0;
        cycle_model(nop_i(), 1'b1, acc, cap, oh, orq);

        // Random traffic with random grants.
        do_reset();
        prog.delete();
        for (int n = 0; n < 400; n++) prog.push_back(rand_i());
        run_prog(-1, 4000, holds, reqs);
        prog.delete();
        repeat (4) prog.push_back(nop_i());
        run_prog(-1, 400, holds, reqs);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
